// File: rtl/delay_tap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : delay_tap_ctrl_pkg
//  Description : Shared types and width helpers for the chip-select delay tap
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package delay_tap_ctrl_pkg;

    localparam int DEF_MAX_TAP = 15;
    localparam int DEF_SETTLE  = 16;
    localparam int DEF_DWELL   = 1024;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_APPLY = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_DWELL      = 3'd3,
        ST_EVAL       = 3'd4,
        ST_FINISH     = 3'd5,
        ST_DONE       = 3'd6
    } cal_state_e;

    function automatic int tap_width(input int max_tap);
        return (max_tap < 1) ? 1 : $clog2(max_tap + 1);
    endfunction

    // The phase counter only ever needs to reach max(SETTLE, DWELL) - 1.
    function automatic int cyc_width(input int settle, input int dwell);
        int m;
        m = (settle > dwell) ? settle : dwell;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_tap_ctrl_err_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_err_counter
//  Description : Saturating error counter with synchronous clear and enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_err_counter
    import delay_tap_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/delay_tap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : delay_tap_ctrl
//  Description : Owns the chip-select delay-line tap: manual inc/dec plus an
//                automatic error-count calibration sweep, applied only while
//                chip-select is idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_tap_ctrl
    import delay_tap_ctrl_pkg::*;
#(
    parameter int MAX_TAP = DEF_MAX_TAP,
    parameter int TAP_W   = tap_width(MAX_TAP),
    parameter int SETTLE  = DEF_SETTLE,
    parameter int DWELL   = DEF_DWELL,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_pulse,
    input  logic             dec_pulse,
    input  logic             cal_start,
    input  logic             cs,
    input  logic             chk_valid,
    input  logic             chk_err,
    output logic [TAP_W-1:0] tap,
    output logic             busy,
    output logic             cal_done,
    output logic             cal_fail,
    output logic [CNT_W-1:0] best_err
);

    localparam int               CYC_W         = cyc_width(SETTLE, DWELL);
    localparam logic [TAP_W-1:0] C_MAX_TAP     = TAP_W'(MAX_TAP);
    localparam logic [CYC_W-1:0] C_SETTLE_LAST = CYC_W'(SETTLE - 1);
    localparam logic [CYC_W-1:0] C_DWELL_LAST  = CYC_W'(DWELL - 1);

    cal_state_e       state_q, state_d;
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] req_q, req_d;
    logic [TAP_W-1:0] orig_q, orig_d;
    logic [TAP_W-1:0] cur_q, cur_d;
    logic [TAP_W-1:0] best_tap_q, best_tap_d;
    logic [CNT_W-1:0] best_err_q, best_err_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             busy_q, busy_d;
    logic             cal_done_q, cal_done_d;
    logic             cal_fail_q, cal_fail_d;
    logic [CNT_W-1:0] err_cnt;
    logic             cnt_clr;
    logic             cnt_en;

    // Checker results are only meaningful once the new tap has settled.
    assign cnt_clr = (state_q == ST_SETTLE);
    assign cnt_en  = (state_q == ST_DWELL) && chk_valid && chk_err;

    sat_err_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (err_cnt)
    );

    // Only move the delay line between frames; a pending request waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q <= '0;
        end else if (cs && (tap_q != req_q)) begin
            tap_q <= req_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            orig_q     <= '0;
            cur_q      <= '0;
            best_tap_q <= '0;
            best_err_q <= '0;
            cyc_q      <= '0;
            busy_q     <= 1'b0;
            cal_done_q <= 1'b0;
            cal_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            orig_q     <= orig_d;
            cur_q      <= cur_d;
            best_tap_q <= best_tap_d;
            best_err_q <= best_err_d;
            cyc_q      <= cyc_d;
            busy_q     <= busy_d;
            cal_done_q <= cal_done_d;
            cal_fail_q <= cal_fail_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        orig_d     = orig_q;
        cur_d      = cur_q;
        best_tap_d = best_tap_q;
        best_err_d = best_err_q;
        cyc_d      = cyc_q;
        busy_d     = busy_q;
        cal_done_d = 1'b0;
        cal_fail_d = cal_fail_q;

        case (state_q)
            ST_IDLE: begin
                if (cal_start) begin
                    orig_d     = req_q;
                    req_d      = '0;
                    cur_d      = '0;
                    best_err_d = '1;
                    best_tap_d = req_q;
                    busy_d     = 1'b1;
                    cal_fail_d = 1'b0;
                    state_d    = ST_WAIT_APPLY;
                end else if (inc_pulse && !dec_pulse) begin
                    req_d = (req_q == C_MAX_TAP) ? '0 : req_q + 1'b1;
                end else if (dec_pulse && !inc_pulse) begin
                    req_d = (req_q == '0) ? C_MAX_TAP : req_q - 1'b1;
                end
            end
            ST_WAIT_APPLY: begin
                if (tap_q == cur_q) begin
                    cyc_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cyc_q == C_SETTLE_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_DWELL;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_DWELL: begin
                if (cyc_q == C_DWELL_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_EVAL;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_EVAL: begin
                // Strict compare: on a tie the earlier (lower) tap is kept.
                if (err_cnt < best_err_q) begin
                    best_err_d = err_cnt;
                    best_tap_d = cur_q;
                end
                if (cur_q == C_MAX_TAP) begin
                    state_d = ST_FINISH;
                end else begin
                    cur_d   = cur_q + 1'b1;
                    req_d   = cur_q + 1'b1;
                    state_d = ST_WAIT_APPLY;
                end
            end
            ST_FINISH: begin
                if (best_err_q == '0) begin
                    req_d      = best_tap_q;
                    cal_fail_d = 1'b0;
                end else begin
                    req_d      = orig_q;
                    cal_fail_d = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (tap_q == req_q) begin
                    cal_done_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tap      = tap_q;
    assign busy     = busy_q;
    assign cal_done = cal_done_q;
    assign cal_fail = cal_fail_q;
    assign best_err = best_err_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_tap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_tap_ctrl
//  Description : Self-checking bench for delay_tap_ctrl (short dwell, narrow
//                error counter so saturation is reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_tap_ctrl;

    localparam int MAX_TAP = 15;
    localparam int TAP_W   = 4;
    localparam int SETTLE  = 16;
    localparam int DWELL   = 32;
    localparam int CNT_W   = 4;
    localparam int ALL     = -1;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             inc_pulse = 1'b0;
    logic             dec_pulse = 1'b0;
    logic             cal_start = 1'b0;
    logic             cs = 1'b1;
    logic             chk_valid = 1'b0;
    logic             chk_err = 1'b0;
    logic [TAP_W-1:0] tap;
    logic             busy;
    logic             cal_done;
    logic             cal_fail;
    logic [CNT_W-1:0] best_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic             inc;
        logic             dec;
        logic             cs;
        logic [TAP_W-1:0] exp_tap;
    } vec_t;

    typedef struct {
        logic [TAP_W-1:0] tap;
        logic [CNT_W-1:0] best;
        logic             fail;
    } cal_exp_t;

    vec_t             vecs[0:32];
    logic [TAP_W-1:0] exp_tap_q[$];
    cal_exp_t         cal_q[$];

    // Per-tap error injection: ALL = error on every checker cycle,
    // otherwise that many errors placed mid-dwell.
    int               prof[0:15];
    bit               chk_en = 1'b0;
    int               chk_k = 0;
    logic [TAP_W-1:0] chk_last = '0;

    always #5 clk = ~clk;

    delay_tap_ctrl #(
        .MAX_TAP (MAX_TAP),
        .TAP_W   (TAP_W),
        .SETTLE  (SETTLE),
        .DWELL   (DWELL),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_pulse (inc_pulse),
        .dec_pulse (dec_pulse),
        .cal_start (cal_start),
        .cs        (cs),
        .chk_valid (chk_valid),
        .chk_err   (chk_err),
        .tap       (tap),
        .busy      (busy),
        .cal_done  (cal_done),
        .cal_fail  (cal_fail),
        .best_err  (best_err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_prof(input int v);
        for (int t = 0; t < 16; t++) prof[t] = v;
    endtask

    function automatic cal_exp_t model_cal(input logic [TAP_W-1:0] orig);
        cal_exp_t r;
        int       best;
        int       bt;
        int       c;
        best = SAT;
        bt   = int'(orig);
        for (int t = 0; t <= MAX_TAP; t++) begin
            c = (prof[t] == ALL) ? DWELL : prof[t];
            if (c > SAT) c = SAT;
            if (c < best) begin
                best = c;
                bt   = t;
            end
        end
        r.best = CNT_W'(best);
        if (best == 0) begin
            r.tap  = TAP_W'(bt);
            r.fail = 1'b0;
        end else begin
            r.tap  = orig;
            r.fail = 1'b1;
        end
        return r;
    endfunction

    // Checker stimulus: errors with chk_valid=0 must never count.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tap != chk_last) chk_k = 0;
            else                 chk_k++;
            chk_last = tap;
            if (chk_en) begin
                if ((prof[tap] == ALL) || (chk_k >= 24 && chk_k < 24 + prof[tap])) begin
                    chk_valid = 1'b1;
                    chk_err   = 1'b1;
                end else begin
                    chk_valid = (chk_k % 2 == 0);
                    chk_err   = (chk_k % 2 != 0);
                end
            end else begin
                chk_valid = 1'b0;
                chk_err   = 1'b0;
            end
        end
    end

    task automatic run_cal(input bit cs_stall, input bit inject);
        cal_exp_t         e;
        bit               done;
        logic [TAP_W-1:0] ptap;
        logic             pcs;
        logic [TAP_W-1:0] t0;
        done = 1'b0;
        cal_q.push_back(model_cal(tap));
        chk_en    = 1'b1;
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        check("busy_after_start", busy, 1);
        if (inject) begin
            for (int c = 0; c < 2000 && tap != 1; c++) step();
            repeat (20) step();
            t0        = tap;
            inc_pulse = 1'b1;
            step();
            inc_pulse = 1'b0;
            repeat (3) step();
            check("inc_ignored_busy", tap, t0);
            cal_start = 1'b1;
            step();
            cal_start = 1'b0;
            repeat (3) step();
            check("cal_start_ignored_busy", tap, t0);
        end
        for (int c = 0; c < 5000 && !done; c++) begin
            cs   = cs_stall ? ((c % 23) >= 5) : 1'b1;
            pcs  = cs;
            ptap = tap;
            step();
            if (!pcs) check("tap_hold_cs_low", tap, ptap);
            if (cal_done) begin
                done = 1'b1;
                e    = cal_q.pop_front();
                check("cal_tap", tap, e.tap);
                check("cal_best_err", best_err, e.best);
                check("cal_fail", cal_fail, e.fail);
                check("busy_falls_with_done", busy, 0);
                cs = 1'b1;
                step();
                check("cal_done_one_cycle", cal_done, 0);
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL cal_timeout: got no cal_done, expected one within 5000 cycles");
            void'(cal_q.pop_front());
        end
        cs     = 1'b1;
        chk_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;

        for (int i = 0; i < 16; i++) vecs[i] = '{1'b1, 1'b0, 1'b1, TAP_W'(i)};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 4'd0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 4'd0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 4'd15};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 4'd15};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 4'd0};
        vecs[21] = '{1'b1, 1'b0, 1'b1, 4'd1};
        vecs[22] = '{1'b1, 1'b0, 1'b1, 4'd2};
        vecs[23] = '{1'b0, 1'b0, 1'b1, 4'd3};
        vecs[24] = '{1'b1, 1'b0, 1'b0, 4'd3};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 4'd3};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 4'd3};
        vecs[27] = '{1'b0, 1'b0, 1'b1, 4'd4};
        vecs[28] = '{1'b1, 1'b1, 1'b1, 4'd4};
        vecs[29] = '{1'b0, 1'b0, 1'b1, 4'd4};
        vecs[30] = '{1'b0, 1'b1, 1'b0, 4'd4};
        vecs[31] = '{1'b0, 1'b0, 1'b1, 4'd3};
        vecs[32] = '{1'b0, 1'b0, 1'b1, 4'd3};
        fill_prof(0);

        #23;
        check("reset_tap", tap, 0);
        check("reset_busy", busy, 0);
        check("reset_cal_done", cal_done, 0);
        check("reset_cal_fail", cal_fail, 0);
        check("reset_best_err", best_err, 0);
        step();
        rst_n = 1'b1;
        step();

        // Manual inc/dec table
        for (int i = 0; i < 33; i++) begin
            inc_pulse = vecs[i].inc;
            dec_pulse = vecs[i].dec;
            cs        = vecs[i].cs;
            exp_tap_q.push_back(vecs[i].exp_tap);
            step();
            inc_pulse = 1'b0;
            dec_pulse = 1'b0;
            check($sformatf("manual_tap[%0d]", i), tap, exp_tap_q.pop_front());
        end
        cs = 1'b1;
        step();

        // Single error-free tap at 6, chip-select stalls during the sweep
        fill_prof(ALL);
        prof[6] = 0;
        run_cal(1'b1, 1'b0);

        // Two error-free taps: the lower one wins
        fill_prof(ALL);
        prof[4] = 0;
        prof[9] = 0;
        run_cal(1'b0, 1'b0);

        // Move to tap 2, then a sweep with no clean tap and saturating counts
        dec_pulse = 1'b1;
        step();
        step();
        dec_pulse = 1'b0;
        step();
        step();
        check("pre_cal_tap", tap, 2);
        fill_prof(ALL);
        prof[11] = 3;
        run_cal(1'b0, 1'b1);

        // Reset asserted mid-dwell at tap 7 aborts the sweep
        fill_prof(0);
        chk_en    = 1'b1;
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        for (int c = 0; c < 3000 && tap != 7; c++) step();
        check("abort_reached_tap7", tap, 7);
        repeat (25) step();
        check("abort_busy_in_dwell", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_tap", tap, 0);
        check("abort_busy", busy, 0);
        check("abort_cal_done", cal_done, 0);
        check("abort_cal_fail", cal_fail, 0);
        check("abort_best_err", best_err, 0);
        repeat (2) step();
        rst_n  = 1'b1;
        pulses = 0;
        repeat (60) begin
            step();
            if (cal_done) pulses++;
        end
        check("abort_no_cal_done", pulses, 0);
        check("abort_busy_stays_low", busy, 0);
        check("abort_tap_stays_0", tap, 0);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
